// File: rtl/barrel_coord_gen_pkg.sv
// Shared constants, FSM encoding and clamp helpers for the barrel-distortion
// coordinate generator and its memory-interface neighbour.
package barrel_pkg;

    localparam int COORD_W    = 12;
    localparam int SCALE_FRAC = 16;
    localparam int SCALE_ONE  = 65536;
    localparam int SCALE_MAX  = 131071;

    localparam int K_W     = 16;
    localparam int DELTA_W = 13;
    localparam int R2_W    = 21;
    localparam int SCALE_W = 18;
    localparam int SQ_W    = 2 * DELTA_W;
    localparam int KR_W    = K_W + R2_W + 1;
    localparam int PX_W    = DELTA_W + SCALE_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUF = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } barrel_state_e;

    function automatic logic [COORD_W-1:0] clamp_coord(input int v, input int hi);
        if (v < 0)       return '0;
        else if (v > hi) return COORD_W'(hi);
        else             return COORD_W'(v);
    endfunction

    function automatic logic out_of_range(input int v, input int hi);
        return (v < 0) || (v > hi);
    endfunction

endpackage

// File: rtl/barrel_coord_gen_if.sv
// Control and coordinate-request bundle of barrel_coord_gen; Math_OOB exists
// only when BARREL_COORD_OOB_EN is defined.
interface barrel_coord_gen_if;
    import barrel_pkg::*;

    // Math_Valid/coord_ready: a coordinate transfers on a clock edge where both
    // are high; once Math_Valid is up, Math_X/Math_Y/Math_OOB hold until then.
    logic                      start;
    logic signed [K_W-1:0]     k_coef;
    logic                      buf_ready;
    logic                      coord_ready;
    logic [COORD_W-1:0]        Math_X;
    logic [COORD_W-1:0]        Math_Y;
    logic                      Math_Valid;
    logic                      busy;
    logic                      frame_done;
    barrel_state_e             dbg_state;
`ifdef BARREL_COORD_OOB_EN
    logic                      Math_OOB;
`endif

    modport slave (
        input  start, k_coef, buf_ready, coord_ready,
        output Math_X, Math_Y, Math_Valid, busy, frame_done, dbg_state
`ifdef BARREL_COORD_OOB_EN
        , output Math_OOB
`endif
    );

    modport master (
        output start, k_coef, buf_ready, coord_ready,
        input  Math_X, Math_Y, Math_Valid, busy, frame_done, dbg_state
`ifdef BARREL_COORD_OOB_EN
        , input Math_OOB
`endif
    );

endinterface

// File: rtl/barrel_radial_scale.sv
// Stages S2-S3: r^2 from the centre offsets, then the saturated radial scale
// 1 + k*r^2 in Q.16. All registers freeze while en_i is low.
module barrel_radial_scale
    import barrel_pkg::*;
#(
    parameter int R2_SHIFT = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en_i,
    input  logic                      valid_i,
    input  logic signed [DELTA_W-1:0] dx_i,
    input  logic signed [DELTA_W-1:0] dy_i,
    input  logic signed [K_W-1:0]     k_i,
    output logic                      valid_o,
    output logic signed [DELTA_W-1:0] dx_o,
    output logic signed [DELTA_W-1:0] dy_o,
    output logic signed [SCALE_W-1:0] scale_o,
    output logic                      busy_o
);

    logic                      v2_q, v3_q;
    logic signed [DELTA_W-1:0] dx2_q, dy2_q, dx3_q, dy3_q;
    logic [R2_W-1:0]           r2_q;
    logic signed [SCALE_W-1:0] scale_q;

    logic signed [SQ_W-1:0]    dx_sq, dy_sq;
    logic [R2_W-1:0]           r2_d;
    logic signed [KR_W-1:0]    kr2, kr2_sh, scale_sum;
    logic signed [SCALE_W-1:0] scale_d;

    always_comb begin
        dx_sq     = SQ_W'(dx_i) * SQ_W'(dx_i);
        dy_sq     = SQ_W'(dy_i) * SQ_W'(dy_i);
        r2_d      = R2_W'(dx_sq + dy_sq);
        // r2 is unsigned; widen with a zero MSB so the product stays signed-correct
        kr2       = KR_W'(k_i) * KR_W'($signed({1'b0, r2_q}));
        kr2_sh    = kr2 >>> R2_SHIFT;
        scale_sum = kr2_sh + KR_W'(SCALE_ONE);
        if (scale_sum < 0)                       scale_d = '0;
        else if (scale_sum > KR_W'(SCALE_MAX))   scale_d = SCALE_W'(SCALE_MAX);
        else                                     scale_d = SCALE_W'(scale_sum);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q    <= 1'b0;
            dx2_q   <= '0;
            dy2_q   <= '0;
            r2_q    <= '0;
            v3_q    <= 1'b0;
            dx3_q   <= '0;
            dy3_q   <= '0;
            scale_q <= '0;
        end else if (en_i) begin
            v2_q    <= valid_i;
            dx2_q   <= dx_i;
            dy2_q   <= dy_i;
            r2_q    <= r2_d;
            v3_q    <= v2_q;
            dx3_q   <= dx2_q;
            dy3_q   <= dy2_q;
            scale_q <= scale_d;
        end
    end

    assign valid_o = v3_q;
    assign dx_o    = dx3_q;
    assign dy_o    = dy3_q;
    assign scale_o = scale_q;
    assign busy_o  = v2_q | v3_q;

endmodule

// File: rtl/barrel_coord_gen.sv
// Raster-order barrel-distortion source-coordinate generator, 4-stage pipeline.
// Define BARREL_COORD_OOB_EN to add the Math_OOB clamp flag.
module barrel_coord_gen
    import barrel_pkg::*;
#(
    parameter int WIDTH    = 1080,
    parameter int HEIGHT   = 960,
    parameter int CX       = 540,
    parameter int CY       = 480,
    parameter int R2_SHIFT = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    barrel_coord_gen_if.slave  bus
);

    localparam logic [COORD_W-1:0]        X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0]        Y_LAST = COORD_W'(HEIGHT - 1);
    localparam logic signed [DELTA_W-1:0] CX_S   = DELTA_W'(CX);
    localparam logic signed [DELTA_W-1:0] CY_S   = DELTA_W'(CY);

    barrel_state_e             state_q;
    logic [COORD_W-1:0]        out_x_q, out_y_q;
    logic signed [K_W-1:0]     k_q;
    logic                      frame_done_q;

    logic                      v1_q;
    logic signed [DELTA_W-1:0] dx1_q, dy1_q;

    logic                      v3, pipe_busy;
    logic signed [DELTA_W-1:0] dx3, dy3;
    logic signed [SCALE_W-1:0] scale3;

    logic                      mv_q;
    logic [COORD_W-1:0]        mx_q, my_q;

    logic                      en, issue, last_pix;
    logic signed [PX_W-1:0]    px, py;
    int                        sx, sy;

    // Only a held, unaccepted output coordinate stalls the whole pipe
    assign en       = ~(mv_q & ~bus.coord_ready);
    assign issue    = (state_q == RUN) & bus.buf_ready;
    assign last_pix = (out_x_q == X_LAST) && (out_y_q == Y_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            out_x_q      <= '0;
            out_y_q      <= '0;
            k_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    k_q     <= bus.k_coef;
                    out_x_q <= '0;
                    out_y_q <= '0;
                    state_q <= WAIT_BUF;
                end
                WAIT_BUF: if (bus.buf_ready) state_q <= RUN;
                RUN: if (en && issue) begin
                    if (last_pix) begin
                        state_q <= DRAIN;
                    end else if (out_x_q == X_LAST) begin
                        out_x_q <= '0;
                        out_y_q <= out_y_q + 1'b1;
                    end else begin
                        out_x_q <= out_x_q + 1'b1;
                    end
                end
                // Nothing is issued in DRAIN, so a lone accepted output is the last pixel
                DRAIN: if (mv_q && bus.coord_ready && !v1_q && !pipe_busy) begin
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q  <= 1'b0;
            dx1_q <= '0;
            dy1_q <= '0;
        end else if (en) begin
            v1_q  <= issue;
            dx1_q <= $signed({1'b0, out_x_q}) - CX_S;
            dy1_q <= $signed({1'b0, out_y_q}) - CY_S;
        end
    end

    barrel_radial_scale #(
        .R2_SHIFT (R2_SHIFT)
    ) u_scale (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en),
        .valid_i (v1_q),
        .dx_i    (dx1_q),
        .dy_i    (dy1_q),
        .k_i     (k_q),
        .valid_o (v3),
        .dx_o    (dx3),
        .dy_o    (dy3),
        .scale_o (scale3),
        .busy_o  (pipe_busy)
    );

    // Arithmetic shift floors toward -inf, so offsets left/above the centre round outward
    always_comb begin
        px = PX_W'(dx3) * PX_W'(scale3);
        py = PX_W'(dy3) * PX_W'(scale3);
        sx = CX + int'(px >>> SCALE_FRAC);
        sy = CY + int'(py >>> SCALE_FRAC);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mv_q <= 1'b0;
            mx_q <= '0;
            my_q <= '0;
        end else if (en) begin
            mv_q <= v3;
            mx_q <= clamp_coord(sx, WIDTH - 1);
            my_q <= clamp_coord(sy, HEIGHT - 1);
        end
    end

`ifdef BARREL_COORD_OOB_EN
    logic oob_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  oob_q <= 1'b0;
        else if (en)   oob_q <= out_of_range(sx, WIDTH - 1) | out_of_range(sy, HEIGHT - 1);
    end

    assign bus.Math_OOB = oob_q;
`endif

    assign bus.Math_X     = mx_q;
    assign bus.Math_Y     = my_q;
    assign bus.Math_Valid = mv_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state_q;

endmodule
